uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter REFERENCE_CLOCK, default 50_000_000, is the clk_in frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, is the serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, is the number of sample ticks per bit; it shall be even and at least 4.
REQ-004 Parameter PARITY_EN, default 0, enables a parity bit when set to 1.
REQ-005 Parameter PARITY_ODD, default 0, selects the parity sense: 0 = even, 1 = odd.
REQ-006 Parameter NBITS, default 16, is the width of the tick divider counter.
REQ-007 Derived constant TICK_COUNT = REFERENCE_CLOCK / (BAUD_RATE*OVERSAMPLE), integer-truncated at elaboration, minimum 1.
REQ-008 Port clk_in, input, 1 bit: single system clock; all logic on the rising edge.
REQ-009 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 Port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-011 Port rx_data, output, 8 bits: last received byte.
REQ-012 Port rx_valid, output, 1 bit: one-clk_in pulse when rx_data is updated.
REQ-013 Port parity_err, output, 1 bit: valid in the rx_valid cycle only; otherwise 0.
REQ-014 Port frame_err, output, 1 bit: valid in the rx_valid cycle only; otherwise 0.
REQ-015 Port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 rx_in shall pass through a 2-flop synchronizer; the FSM uses only the synchronized value (rx_s), which adds 2 cycles of latency.
REQ-017 The tick generator shall pulse tick for one cycle every TICK_COUNT clk_in cycles. Its counter shall restart at 0 on the IDLE->START transition so that sampling is phase-aligned to the start edge.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-019 IDLE->START on rx_s = 0; the tick counter and the sample counter clear.
REQ-020 In START, at tick number OVERSAMPLE/2: if rx_s = 1, return to IDLE (glitch rejection, no output); else go to DATA with the sample counter cleared.
REQ-021 In DATA, sample rx_s every OVERSAMPLE ticks (mid-bit); shift it in LSB first. After 8 bits, go to PARITY if PARITY_EN = 1, else to STOP.
REQ-022 In PARITY, sample one bit; the parity error flag is set if the XOR of the 8 data bits and the parity bit is not PARITY_ODD.
REQ-023 In STOP, sample one bit at mid-bit. rx_data is loaded and rx_valid pulses in the next cycle; frame_err = ~stop sample.
REQ-024 After STOP: if the stop sample is 1, go to IDLE immediately (half a bit early, which permits back-to-back frames); if it is 0, go to BREAK_WAIT.
REQ-025 BREAK_WAIT->IDLE on the first cycle with rx_s = 1; no start detection occurs while in BREAK_WAIT.
REQ-026 rx_data shall hold its value until the next rx_valid; there is no backpressure, and a new frame overwrites it.
REQ-027 Latency from the stop-bit mid-sample tick to rx_valid shall be exactly 1 clk_in cycle.
REQ-028 parity_err shall be forced to 0 when PARITY_EN = 0.

Reset
REQ-029 Asserting reset at any time, including mid-frame, shall force: FSM = IDLE, all counters = 0, synchronizer flops = 1, rx_data = 8'h00, rx_valid = 0, parity_err = 0, frame_err = 0, rx_busy = 0.
REQ-030 A frame in progress when reset is asserted shall be discarded with no rx_valid pulse. Reception restarts on the first falling edge seen after reset deasserts.

Structure
REQ-031 Package uart_pkg shall hold the FSM state typedef, the parity-sense constants, and the TICK_COUNT calculation function shared with the transmitter.
REQ-032 Sub-module uart_baud_tick (parameters REFERENCE_CLOCK, BAUD_RATE, OVERSAMPLE, NBITS; ports clk_in, reset, clear, tick) shall implement REQ-017.

Verification
REQ-033 Defaults (TICK_COUNT = 27, bit = 432 clocks): send 0xA5 with 8N1 -> exactly one rx_valid, rx_data = 8'hA5, frame_err = 0, rx_busy low within 1 bit time after the stop bit begins.
REQ-034 Send 0x00 then 0xFF back-to-back with zero idle -> two rx_valid pulses, data 8'h00 then 8'hFF, no errors.
REQ-035 PARITY_EN = 1, PARITY_ODD = 0: send 0x03 with parity bit 1 -> rx_data = 8'h03, parity_err = 1 in the rx_valid cycle; with parity bit 0 -> parity_err = 0.
REQ-036 Send 0x55 with the stop bit driven 0, then hold the line low for 2000 cycles -> one rx_valid with frame_err = 1, rx_busy stays high until the line returns high, and no second frame is reported.
REQ-037 Drive a 100-cycle low glitch on an idle line -> no rx_valid, FSM back in IDLE.
REQ-038 Assert reset during bit 4 of a frame -> all outputs at reset values and no rx_valid; a subsequent 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-sense constants and
// the divider calculation used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } uart_state_e;

    localparam logic PARITY_SENSE_EVEN = 1'b0;
    localparam logic PARITY_SENSE_ODD  = 1'b1;

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int calc_tick_count(input int ref_clock, input int baud, input int oversample);
        int q;
        q = ref_clock / (baud * oversample);
        if (q < 1) begin
            q = 1;
        end
        return q;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_COUNT clocks.
// While clear is high the counter is held at 0, so the first tick after
// clear drops lands exactly TICK_COUNT cycles later.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int REFERENCE_CLOCK = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int NBITS           = 16
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int TICK_COUNT = calc_tick_count(REFERENCE_CLOCK, BAUD_RATE, OVERSAMPLE);
    localparam logic [NBITS-1:0] TICK_LAST = NBITS'(TICK_COUNT - 1);

    logic [NBITS-1:0] cnt_q;
    logic [NBITS-1:0] cnt_d;

    // Next count and tick pulse; wrap at TICK_LAST, restart on clear.
    always_comb begin
        cnt_d = cnt_q + NBITS'(1);
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == TICK_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, optional parity, one stop bit, oversampled
// with mid-bit sampling aligned to the falling start edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int REFERENCE_CLOCK = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0,
    parameter int NBITS           = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
        $error("OVERSAMPLE must be even and at least 4");
    end

    localparam int SW = $clog2(OVERSAMPLE) + 1;
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PARITY_SENSE_ODD : PARITY_SENSE_EVEN;

    logic [1:0]  sync_q, sync_d;
    logic        rx_s;
    uart_state_e state_q, state_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        perr_flag_q, perr_flag_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;
    logic        tick;
    logic        tick_clear;

    assign sync_d     = {sync_q[0], rx_in};
    assign rx_s       = sync_q[1];
    assign tick_clear = (state_q == IDLE);

    uart_baud_tick #(
        .REFERENCE_CLOCK (REFERENCE_CLOCK),
        .BAUD_RATE       (BAUD_RATE),
        .OVERSAMPLE      (OVERSAMPLE),
        .NBITS           (NBITS)
    ) u_baud_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (tick_clear),
        .tick   (tick)
    );

    // Two-flop synchronizer on the serial line, idling high.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Frame FSM: start validation, mid-bit sampling, parity, stop and break handling.
    always_comb begin
        state_d      = state_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_flag_d  = perr_flag_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                samp_d      = '0;
                bit_d       = '0;
                perr_flag_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (samp_q == HALF_LAST) begin
                        samp_d  = '0;
                        bit_d   = '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (samp_q == FULL_LAST) begin
                        samp_d  = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
            end

            PARITY: begin
                if (tick) begin
                    if (samp_q == FULL_LAST) begin
                        samp_d      = '0;
                        perr_flag_d = ((^shift_q) ^ rx_s) != PAR_SENSE;
                        state_d     = STOP;
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (samp_q == FULL_LAST) begin
                        samp_d       = '0;
                        rx_data_d    = shift_q;
                        rx_valid_d   = 1'b1;
                        frame_err_d  = ~rx_s;
                        parity_err_d = (PARITY_EN != 0) ? perr_flag_q : 1'b0;
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        state_d      = rx_s ? IDLE : BREAK_WAIT;
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
            end

            BREAK_WAIT: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            samp_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_flag_q  <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_flag_q  <= perr_flag_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != IDLE);

endmodule
